seven_segment_display_decoder__4: RTL and testbench
===================================================

Name: seven_segment_display_decoder__4

Overview:
- Receive side of the 4-digit multiplexed 7-segment interface: samples externally driven anode/cathode lines, waits for each digit's scan dwell to settle, and decodes the segment patterns back to hex nibbles.
- Reassembles the 16-bit value, flags undecodable patterns, and flags scan loss.
- Used for loopback self-test of the display driver and for reading external instruments with multiplexed LED displays.

Parameters:
- SETTLE_CYCLES, 64, consecutive identical synchronized samples required before a digit is accepted (>=2).
- TIMEOUT_CYCLES, 1048576, cycles with no accepted digit before the frame is declared stale.
- ANODE_ACTIVE_HIGH, 1, 1: anode line high selects the digit; 0: low selects.
- CATHODE_ACTIVE_LOW, 1, 1: cathode line low lights the segment; 0: high lights.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- anode  input  4  digit selects, asynchronous to clock; bit0 = least significant digit, bit3 = most significant.
- cathode  input  7  segments a..g on bits 0..6, asynchronous to clock; dp not monitored.
- data  output  16  last complete frame; digit3 in [15:12], digit0 in [3:0].
- data_valid  output  1  one-cycle pulse when data updates.
- changed  output  1  one-cycle pulse, coincident with data_valid, when the new data differs from the previous data.
- decode_error  output  1  one-cycle pulse per accepted digit whose pattern is not in the table.
- stale  output  1  level; high when no accepted digit has occurred for TIMEOUT_CYCLES.

Behaviour:
- Reset (async assert, sync deassert through the flops):
  - data=0, data_valid=0, changed=0, decode_error=0, stale=1.
  - Nibble store=0, seen[3:0]=0, counters=0, synchronizers=0.
- Input path:
  - Two-flop synchronizer on all 11 lines.
  - Normalize: sel = anode XOR {4{~ANODE_ACTIVE_HIGH}}; seg = cathode XOR {7{CATHODE_ACTIVE_LOW}}. seg bit=1 means lit.
- Settle filter:
  - Compare {sel,seg} with the previous cycle's value. On any difference, or when sel is not one-hot (0000 or multiple bits set), clear stable_count and the accepted flag.
  - Otherwise increment stable_count, saturating.
  - When stable_count reaches SETTLE_CYCLES-1 and the accepted flag is clear, accept the digit and set the flag.
  - Exactly one accept per dwell, however long the dwell lasts.
  - A non-one-hot sel is blanking/ghosting: never an error.
- Decode table (seg[6:0] = gfedcba -> nibble):
  - 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9.
  - 77=A, 7C=b, 39=C, 5E=d, 79=E, 71=F.
  - All other patterns, including blank 00, are errors.
- On accept of digit k:
  - Valid pattern: nibble[k] <= decoded value; seen[k] <= 1.
  - Invalid pattern: decode_error pulses the cycle after accept; seen[k] <= 0; nibble[k] unchanged.
  - Re-accepting an already-seen digit overwrites nibble[k]. No frame event.
- Frame completion:
  - In the cycle after seen becomes 1111: data <= {nibble3..nibble0}, data_valid pulses, changed pulses if the new data differs from the old, and seen <= 0000.
  - Latency: data_valid occurs 2 cycles after the accept of the final digit (store cycle, then frame cycle).
  - The 2-flop synchronizer adds 2 further cycles ahead of the filter.
  - If an accept lands in the same cycle that seen is cleared, the clear wins for all other bits and the new accept sets its own bit. No sample is lost.
- Timeout:
  - idle_count increments each cycle and is cleared on every accept.
  - At idle_count == TIMEOUT_CYCLES-1: stale <= 1 and seen <= 0000. data is held, not cleared.
  - stale clears in the same cycle data_valid next pulses.
- Width rules: stable_count width is clog2(SETTLE_CYCLES)+1; idle_count width is clog2(TIMEOUT_CYCLES)+1. Both saturate and never wrap.
- Reset mid-frame discards partial nibbles and seen bits. The first frame after reset needs all four digits again.

Test Plan (bench uses SETTLE_CYCLES=4, TIMEOUT_CYCLES=64, default polarities, dwell 20 cycles/digit):
- Scan value 16'h1A3F (anode 0001: cathode ~71; 0010: ~4F; 0100: ~77; 1000: ~06) -> data=16'h1A3F, one data_valid pulse and one changed pulse per full scan, decode_error never asserted.
- Repeat the same scan 3 times -> data_valid pulses 3 times; changed pulses only on the first; stale falls at the first data_valid.
- Digit 2 driven with pattern 7'h00 (blank) -> decode_error pulses once per scan; data_valid is never asserted while digit 2 stays invalid.
- 2-cycle glitch to 0110 anodes and 1-cycle cathode spikes shorter than 4 cycles between dwells -> no decode_error, no extra accepts, data=correct value.
- Stop scanning (anode=0000) for 80 cycles after a valid frame -> stale rises at cycle 64 after the last accept, data held; resume scanning with 16'hBEEF -> data=16'hBEEF, stale falls with data_valid.
- Assert reset_n low after 2 digits of a scan, release, then scan 16'h0042 -> outputs return to reset values immediately; the first data_valid requires all four digits; data=16'h0042.

Source files
------------

// File: rtl/seven_segment_display_decoder__4.sv
// Receive side of a 4-digit multiplexed 7-segment display: synchronizes the
// anode/cathode lines, settles each digit dwell and decodes frames to hex.
module seven_segment_display_decoder__4 #(
  parameter int unsigned SETTLE_CYCLES      = 64,
  parameter int unsigned TIMEOUT_CYCLES     = 1048576,
  parameter bit          ANODE_ACTIVE_HIGH  = 1'b1,
  parameter bit          CATHODE_ACTIVE_LOW = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  anode,
  input  logic [6:0]  cathode,
  output logic [15:0] data,
  output logic        data_valid,
  output logic        changed,
  output logic        decode_error,
  output logic        stale
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES) + 1;
  localparam int unsigned IW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [SW-1:0] SETTLE_HIT = SW'(SETTLE_CYCLES - 2);
  localparam logic [SW-1:0] STABLE_MAX = '1;
  localparam logic [IW-1:0] IDLE_HIT   = IW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_MAX   = '1;

  logic [3:0]       anode_s1, anode_s2;
  logic [6:0]       cathode_s1, cathode_s2;
  logic [10:0]      prev_q;
  logic [SW-1:0]    stable_count_q;
  logic             accepted_q;
  logic [IW-1:0]    idle_count_q;
  logic [3:0][3:0]  nibbles_q, nibbles_d;
  logic [3:0]       seen_q, seen_d;

  logic [3:0] sel_c;
  logic [6:0] seg_c;
  logic       one_hot_c, stable_c, accept_c, frame_c, timeout_c;
  logic [1:0] digit_c;
  logic [3:0] nib_c;
  logic       valid_c;

  // Normalize to sel=1 selects, seg=1 lit
  assign sel_c     = anode_s2 ^ {4{~ANODE_ACTIVE_HIGH}};
  assign seg_c     = cathode_s2 ^ {7{CATHODE_ACTIVE_LOW}};
  assign one_hot_c = (sel_c != 4'd0) && ((sel_c & (sel_c - 4'd1)) == 4'd0);
  assign stable_c  = one_hot_c && ({sel_c, seg_c} == prev_q);
  assign accept_c  = stable_c && (stable_count_q == SETTLE_HIT) && !accepted_q;
  assign digit_c   = {sel_c[3] | sel_c[2], sel_c[3] | sel_c[1]};
  assign frame_c   = &seen_q;
  assign timeout_c = (idle_count_q == IDLE_HIT);

  // Segment pattern (gfedcba) to hex nibble
  always_comb begin
    nib_c   = 4'd0;
    valid_c = 1'b1;
    case (seg_c)
      7'h3F: nib_c = 4'h0;
      7'h06: nib_c = 4'h1;
      7'h5B: nib_c = 4'h2;
      7'h4F: nib_c = 4'h3;
      7'h66: nib_c = 4'h4;
      7'h6D: nib_c = 4'h5;
      7'h7D: nib_c = 4'h6;
      7'h07: nib_c = 4'h7;
      7'h7F: nib_c = 4'h8;
      7'h6F: nib_c = 4'h9;
      7'h77: nib_c = 4'hA;
      7'h7C: nib_c = 4'hB;
      7'h39: nib_c = 4'hC;
      7'h5E: nib_c = 4'hD;
      7'h79: nib_c = 4'hE;
      7'h71: nib_c = 4'hF;
      default: valid_c = 1'b0;
    endcase
  end

  // Frame/timeout clear first, so a coincident accept still lands its own bit
  always_comb begin
    nibbles_d = nibbles_q;
    seen_d    = (frame_c || timeout_c) ? 4'd0 : seen_q;
    if (accept_c) begin
      if (valid_c) nibbles_d[digit_c] = nib_c;
      seen_d[digit_c] = valid_c;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      anode_s1       <= 4'd0;
      anode_s2       <= 4'd0;
      cathode_s1     <= 7'd0;
      cathode_s2     <= 7'd0;
      prev_q         <= 11'd0;
      stable_count_q <= '0;
      accepted_q     <= 1'b0;
      idle_count_q   <= '0;
      nibbles_q      <= '0;
      seen_q         <= 4'd0;
      data           <= 16'd0;
      data_valid     <= 1'b0;
      changed        <= 1'b0;
      decode_error   <= 1'b0;
      stale          <= 1'b1;
    end else begin
      anode_s1   <= anode;
      anode_s2   <= anode_s1;
      cathode_s1 <= cathode;
      cathode_s2 <= cathode_s1;
      prev_q     <= {sel_c, seg_c};

      if (!stable_c)                        stable_count_q <= '0;
      else if (stable_count_q != STABLE_MAX) stable_count_q <= stable_count_q + SW'(1);
      accepted_q <= stable_c && (accepted_q || accept_c);

      if (accept_c)                      idle_count_q <= '0;
      else if (idle_count_q != IDLE_MAX) idle_count_q <= idle_count_q + IW'(1);

      nibbles_q    <= nibbles_d;
      seen_q       <= seen_d;
      decode_error <= accept_c && !valid_c;
      data_valid   <= frame_c;
      changed      <= frame_c && (nibbles_q != data);
      if (frame_c) data <= nibbles_q;

      if (frame_c)        stale <= 1'b0;
      else if (timeout_c) stale <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seven_segment_display_decoder__4.sv
// Directed-stimulus bench for the 7-segment receive decoder with a
// sample-history reference model checked every cycle.
module tb_seven_segment_display_decoder__4;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 64;
  localparam int DWELL   = 20;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  anode   = 4'd0;
  logic [6:0]  cathode = 7'h7F;
  logic [15:0] data;
  logic        data_valid, changed, decode_error, stale;

  always #5 clock = ~clock;

  seven_segment_display_decoder__4 #(
    .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT),
    .ANODE_ACTIVE_HIGH(1'b1), .CATHODE_ACTIVE_LOW(1'b1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .anode(anode), .cathode(cathode),
    .data(data), .data_valid(data_valid), .changed(changed),
    .decode_error(decode_error), .stale(stale)
  );

  int n_cmp = 0, n_bad = 0;
  int dv_cnt = 0, ch_cnt = 0, err_cnt = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string name, input int unsigned act, input int unsigned exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference model state: raw sample history plus the decoded frame view
  logic [10:0] pipe0 = '0, pipe1 = '0, m_prev = '0;
  int          m_run = 0, m_idle = 0;
  logic [3:0]  m_nib [4] = '{default: 4'd0};
  bit          m_seen [4] = '{default: 1'b0};
  logic [15:0] m_data = '0;
  bit          m_dv = 0, m_ch = 0, m_err = 0, m_stale = 1;

  task automatic model_reset();
    pipe0 = '0; pipe1 = '0; m_prev = '0; m_run = 0; m_idle = 0;
    for (int i = 0; i < 4; i++) begin m_nib[i] = 4'd0; m_seen[i] = 0; end
    m_data = '0; m_dv = 0; m_ch = 0; m_err = 0; m_stale = 1;
  endtask

  task automatic model_step();
    logic [10:0] cur;
    logic [3:0]  sel;
    logic [6:0]  lit;
    logic [15:0] frame_val;
    bit          oh, acc, frame, tmo;
    int          k, v;
    cur   = pipe1;
    pipe1 = pipe0;
    pipe0 = {anode, cathode};
    sel   = cur[10:7];
    lit   = ~cur[6:0];
    oh    = ($countones(sel) == 1);
    if (oh && cur == m_prev) m_run = (m_run < 1000) ? m_run + 1 : m_run;
    else                     m_run = oh ? 1 : 0;
    m_prev = cur;
    acc   = oh && (m_run == SETTLE);
    frame = m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3];
    tmo   = (m_idle == TIMEOUT - 1);
    m_dv = frame; m_ch = 0; m_err = 0;
    if (frame) begin
      frame_val = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
      m_ch      = (frame_val != m_data);
      m_data    = frame_val;
      m_stale   = 0;
    end else if (tmo) m_stale = 1;
    if (frame || tmo) for (int i = 0; i < 4; i++) m_seen[i] = 0;
    if (acc) begin
      k = 0;
      for (int i = 0; i < 4; i++) if (sel[i]) k = i;
      v = -1;
      for (int i = 0; i < 16; i++) if (seg_tab[i] == lit) v = i;
      if (v >= 0) begin m_nib[k] = 4'(v); m_seen[k] = 1; end
      else begin m_seen[k] = 0; m_err = 1; end
      m_idle = 0;
    end else if (m_idle < TIMEOUT) m_idle++;
  endtask

  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n) model_reset();
    else          model_step();
  end

  // Every-cycle comparison against the model, plus pulse tallies
  initial forever begin
    @(negedge clock);
    check("data", 32'(data), 32'(m_data));
    check("data_valid", 32'(data_valid), 32'(m_dv));
    check("changed", 32'(changed), 32'(m_ch));
    check("decode_error", 32'(decode_error), 32'(m_err));
    check("stale", 32'(stale), 32'(m_stale));
    if (data_valid)   dv_cnt++;
    if (changed)      ch_cnt++;
    if (decode_error) err_cnt++;
  end

  task automatic hold(input logic [3:0] a, input logic [6:0] c, input int n);
    anode = a; cathode = c;
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic scan(input logic [15:0] val, input int ndig, input bit blank2, input bit glitch);
    logic [6:0] c;
    logic [3:0] a;
    for (int d = 0; d < ndig; d++) begin
      c = ~seg_tab[val[4*d +: 4]];
      if (blank2 && d == 2) c = 7'h7F;
      a = 4'(1 << d);
      if (glitch) begin
        hold(4'b0110, 7'h00, 2);
        hold(a, c ^ 7'h12, 1);
        hold(a, c, 1);
        hold(a, c ^ 7'h40, 1);
        hold(a, c, DWELL - 3);
      end else hold(a, c, DWELL);
    end
    if (ndig == 4) hold(4'd0, 7'h7F, 10);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b1;
    check("rst_data", 32'(data), 32'h0);
    check("rst_stale", 32'(stale), 32'h1);
    check("rst_dv", 32'(data_valid), 32'h0);
    hold(4'd0, 7'h7F, 4);

    scan(16'h1A3F, 4, 0, 0);
    check("t1_data", 32'(data), 32'h1A3F);
    check("t1_dv_cnt", dv_cnt, 1);
    check("t1_ch_cnt", ch_cnt, 1);
    check("t1_err_cnt", err_cnt, 0);
    check("t1_stale", 32'(stale), 32'h0);

    repeat (2) scan(16'h1A3F, 4, 0, 0);
    check("t2_dv_cnt", dv_cnt, 3);
    check("t2_ch_cnt", ch_cnt, 1);

    repeat (2) scan(16'hC0DE, 4, 1, 0);
    check("t3_err_cnt", err_cnt, 2);
    check("t3_dv_cnt", dv_cnt, 3);
    check("t3_data", 32'(data), 32'h1A3F);

    scan(16'hC0DE, 4, 0, 1);
    check("t4_data", 32'(data), 32'hC0DE);
    check("t4_dv_cnt", dv_cnt, 4);
    check("t4_ch_cnt", ch_cnt, 2);
    check("t4_err_cnt", err_cnt, 2);
    check("t4_stale", 32'(stale), 32'h0);

    hold(4'd0, 7'h7F, 80);
    check("t5_stale", 32'(stale), 32'h1);
    check("t5_data_held", 32'(data), 32'hC0DE);
    scan(16'hBEEF, 4, 0, 0);
    check("t5_data", 32'(data), 32'hBEEF);
    check("t5_dv_cnt", dv_cnt, 5);
    check("t5_ch_cnt", ch_cnt, 3);
    check("t5_stale_fall", 32'(stale), 32'h0);

    scan(16'h0042, 2, 0, 0);
    reset_n = 1'b0;
    #1;
    check("t6_rst_data", 32'(data), 32'h0);
    check("t6_rst_stale", 32'(stale), 32'h1);
    hold(4'd0, 7'h7F, 3);
    reset_n = 1'b1;
    scan(16'h0042, 3, 0, 0);
    check("t6_partial_dv_cnt", dv_cnt, 5);
    scan(16'h0042, 4, 0, 0);
    check("t6_data", 32'(data), 32'h0042);
    check("t6_dv_cnt", dv_cnt, 6);
    check("t6_ch_cnt", ch_cnt, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
